// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcode encoding of the 8-bit ALU
// and the issuer state machine encoding.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_INC  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_DEC  = 4'b0011;
    localparam logic [3:0] OP_MUL  = 4'b0100;
    localparam logic [3:0] OP_DIV  = 4'b0101;
    localparam logic [3:0] OP_SHL  = 4'b0110;
    localparam logic [3:0] OP_SHR  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_INV  = 4'b1010;
    localparam logic [3:0] OP_NAND = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_XOR  = 4'b1101;
    localparam logic [3:0] OP_XNOR = 4'b1110;
    localparam logic [3:0] OP_BUF  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_HOLD
    } issue_state_t;

    // A divide with a zero divisor never reaches the ALU; the issuer substitutes a result.
    function automatic logic is_div_zero(input logic [3:0] cmd, input logic b_zero);
        return (cmd == OP_DIV) && b_zero;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO for the ALU issuer; DEPTH must be a power of two so
// the pointers wrap naturally.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; stale entries are never read because pops are gated by empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issue stage for the 8-bit ALU: buffers commands, drives the ALU one command at a
// time, and hands each registered 16-bit result downstream.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 8,
    parameter int RW    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DW-1:0]            in_a,
    input  logic [DW-1:0]            in_b,
    input  logic [3:0]               in_cmd,
    output logic [DW-1:0]            alu_a,
    output logic [DW-1:0]            alu_b,
    output logic [3:0]               alu_cmd,
    output logic                     alu_oe,
    input  logic [RW-1:0]            alu_dout,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [RW-1:0]            res_data,
    output logic                     res_err,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int FW = 2*DW + 4;

    issue_state_t  state;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [FW-1:0] fifo_wdata;
    logic [FW-1:0] fifo_rdata;
    logic [DW-1:0] head_a;
    logic [DW-1:0] head_b;
    logic [3:0]    head_cmd;
    logic          head_div_zero;
    logic          op_div_zero;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [3:0]    op_cmd;
    logic          oe_q;

    // in_ready uses the registered count only, so a full FIFO refuses a push even on a popping cycle.
    assign in_ready      = !fifo_full;
    assign fifo_push     = in_valid && !fifo_full;
    assign fifo_wdata    = {in_a, in_b, in_cmd};
    assign {head_a, head_b, head_cmd} = fifo_rdata;
    assign head_div_zero = is_div_zero(head_cmd, head_b == '0);
    assign op_div_zero   = is_div_zero(op_cmd, op_b == '0);

    always_comb begin
        fifo_pop = 1'b0;
        if (!fifo_empty) begin
            fifo_pop = (state == ST_IDLE) || ((state == ST_HOLD) && res_ready);
        end
    end

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (FW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Issue FSM: a popped command spends one cycle in DRIVE with the ALU enabled,
    // then its result is held in HOLD until downstream takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_a      <= '0;
            op_b      <= '0;
            op_cmd    <= '0;
            oe_q      <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        op_a   <= head_a;
                        op_b   <= head_b;
                        op_cmd <= head_cmd;
                        oe_q   <= !head_div_zero;
                        state  <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    oe_q      <= 1'b0;
                    res_valid <= 1'b1;
                    if (op_div_zero) begin
                        res_data <= '1;
                        res_err  <= 1'b1;
                    end else begin
                        res_data <= alu_dout;
                        res_err  <= 1'b0;
                    end
                    state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (fifo_pop) begin
                            op_a   <= head_a;
                            op_b   <= head_b;
                            op_cmd <= head_cmd;
                            oe_q   <= !head_div_zero;
                            state  <= ST_DRIVE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    oe_q  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign alu_a   = op_a;
    assign alu_b   = op_b;
    assign alu_cmd = op_cmd;
    assign alu_oe  = oe_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer with a behavioural model of the 8-bit ALU
// as the consumer and a queue of expected results.
module tb_alu_cmd_issuer;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int DW    = 8;
    localparam int RW    = 16;

    typedef struct packed {
        logic [15:0] data;
        logic        err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic [3:0]    in_cmd = '0;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [3:0]    alu_cmd;
    logic          alu_oe;
    logic [RW-1:0] alu_dout;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [RW-1:0] res_data;
    logic          res_err;
    logic [2:0]    fifo_count;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    logic [7:0] tab_a   [9] = '{8'h12, 8'hFF, 8'h0F, 8'hA5, 8'h3C, 8'h80, 8'h77, 8'h01, 8'hE4};
    logic [7:0] tab_b   [9] = '{8'h34, 8'h02, 8'hF0, 8'h5A, 8'h0C, 8'h08, 8'h11, 8'hFE, 8'h03};
    logic [3:0] tab_cmd [9] = '{OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_DIV, OP_NAND, OP_ADD, OP_SHL};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] alu_func(input logic [7:0] a, input logic [7:0] b, input logic [3:0] cmd);
        logic [15:0] a16;
        logic [15:0] b16;
        a16 = {8'h00, a};
        b16 = {8'h00, b};
        case (cmd)
            OP_ADD:  return a16 + b16;
            OP_INC:  return a16 + 16'd1;
            OP_SUB:  return a16 - b16;
            OP_DEC:  return a16 - 16'd1;
            OP_MUL:  return a16 * b16;
            OP_DIV:  return (b == 8'h00) ? 16'h0000 : a16 / b16;
            OP_SHL:  return a16 << 1;
            OP_SHR:  return a16 >> 1;
            OP_AND:  return a16 & b16;
            OP_OR:   return a16 | b16;
            OP_INV:  return ~a16;
            OP_NAND: return ~(a16 & b16);
            OP_NOR:  return ~(a16 | b16);
            OP_XOR:  return a16 ^ b16;
            OP_XNOR: return ~(a16 ^ b16);
            default: return a16;
        endcase
    endfunction

    function automatic exp_t expect_of(input logic [7:0] a, input logic [7:0] b, input logic [3:0] cmd);
        exp_t e;
        if (cmd == OP_DIV && b == 8'h00) begin
            e.data = 16'hFFFF;
            e.err  = 1'b1;
        end else begin
            e.data = alu_func(a, b, cmd);
            e.err  = 1'b0;
        end
        return e;
    endfunction

    // The ALU only drives its result while enabled.
    always_comb alu_dout = alu_oe ? alu_func(alu_a, alu_b, alu_cmd) : 16'h0000;

    alu_cmd_issuer #(.DEPTH(DEPTH), .DW(DW), .RW(RW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_cmd     (in_cmd),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cmd    (alu_cmd),
        .alu_oe     (alu_oe),
        .alu_dout   (alu_dout),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_err    (res_err),
        .fifo_count (fifo_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one command and waits for it to be accepted; the expectation is queued on acceptance.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] cmd,
                        output int acc_cyc, output bit ok);
        bit acc;
        ok      = 1'b0;
        acc_cyc = -1;
        in_a     = a;
        in_b     = b;
        in_cmd   = cmd;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            acc = in_ready;
            step();
            if (acc) begin
                ok      = 1'b1;
                acc_cyc = cyc;
                sb.push_back(expect_of(a, b, cmd));
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    // Waits for one result handshake, optionally with random backpressure.
    task automatic collect(input bit rnd, output logic [15:0] d, output logic e, output int t,
                           output int oe_cnt, output bit unstable, output bit ok);
        logic [15:0] hd;
        logic        he;
        bit          have;
        ok       = 1'b0;
        oe_cnt   = 0;
        unstable = 1'b0;
        have     = 1'b0;
        d        = '0;
        e        = 1'b0;
        t        = -1;
        hd       = '0;
        he       = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (rnd) res_ready = 1'($urandom_range(0, 1));
            oe_cnt += int'(alu_oe);
            if (res_valid) begin
                if (have && (res_data !== hd || res_err !== he)) unstable = 1'b1;
                hd   = res_data;
                he   = res_err;
                have = 1'b1;
                if (res_ready) begin
                    d  = res_data;
                    e  = res_err;
                    t  = cyc;
                    ok = 1'b1;
                    step();
                    break;
                end
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        res_ready = 1'b0;
        #12;
        total++; if (in_ready !== 1'b1)  begin bad++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_res_valid got %b want 0", res_valid); end
        total++; if (alu_oe !== 1'b0)    begin bad++; $display("[TB] FAIL reset_alu_oe got %b want 0", alu_oe); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("[TB] FAIL reset_fifo_count got %0d want 0", fifo_count); end
        total++; if (res_data !== 16'h0000 || res_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_result got %h/%b want 0000/0", res_data, res_err); end
        total++; if ({alu_a, alu_b, alu_cmd} !== 20'h0) begin bad++; $display("[TB] FAIL reset_alu_bus got %h want 0", {alu_a, alu_b, alu_cmd}); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        total++; if (res_valid !== 1'b0 || alu_oe !== 1'b0) begin bad++; $display("[TB] FAIL idle_after_reset got valid=%b oe=%b want 0/0", res_valid, alu_oe); end
    endtask

    task automatic test_single_add();
        int          acc_cyc;
        int          t;
        int          oe_cnt;
        bit          ok;
        bit          unst;
        logic [15:0] d;
        logic        e;
        res_ready = 1'b1;
        send(8'hCE, 8'h9B, OP_ADD, acc_cyc, ok);
        collect(1'b0, d, e, t, oe_cnt, unst, ok);
        void'(sb.pop_front());
        total++; if (!ok) begin bad++; $display("[TB] FAIL add_timeout got no result want one"); end
        total++; if (t - acc_cyc !== 2) begin bad++; $display("[TB] FAIL add_latency got %0d want 2", t - acc_cyc); end
        total++; if (oe_cnt !== 1) begin bad++; $display("[TB] FAIL add_oe_cycles got %0d want 1", oe_cnt); end
        total++; if (d !== 16'h0169 || e !== 1'b0) begin bad++; $display("[TB] FAIL add_result got %h/%b want 0169/0", d, e); end
        step();
        total++; if (res_valid !== 1'b0 || alu_oe !== 1'b0) begin bad++; $display("[TB] FAIL add_after got valid=%b oe=%b want 0/0", res_valid, alu_oe); end
    endtask

    task automatic test_fill_drain();
        int          acc_cyc;
        int          first;
        int          t;
        int          prev;
        int          oe_cnt;
        bit          ok;
        bit          unst;
        logic [15:0] d;
        logic        e;
        exp_t        ex;
        res_ready = 1'b0;
        first = 0;
        prev  = 0;
        for (int i = 0; i < 5; i++) begin
            send(tab_a[i], tab_b[i], tab_cmd[i], acc_cyc, ok);
            if (i == 0) first = acc_cyc;
            total++; if (!ok || acc_cyc !== first + i) begin bad++; $display("[TB] FAIL fill_accept%0d got cyc %0d want %0d", i, acc_cyc, first + i); end
        end
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL fill_in_ready got %b want 0", in_ready); end
        total++; if (fifo_count !== 3'd4) begin bad++; $display("[TB] FAIL fill_count got %0d want 4", fifo_count); end
        in_a = tab_a[5]; in_b = tab_b[5]; in_cmd = tab_cmd[5]; in_valid = 1'b1;
        step(); step(); step();
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0 || fifo_count !== 3'd4) begin bad++; $display("[TB] FAIL fill_sixth got ready=%b count=%0d want 0/4", in_ready, fifo_count); end
        res_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            collect(1'b0, d, e, t, oe_cnt, unst, ok);
            ex = (sb.size() > 0) ? sb.pop_front() : exp_t'('0);
            total++; if (!ok || d !== ex.data || e !== ex.err) begin bad++; $display("[TB] FAIL drain%0d got %h/%b want %h/%b", k, d, e, ex.data, ex.err); end
            if (k > 0) begin
                total++; if (t - prev !== 2) begin bad++; $display("[TB] FAIL drain_rate%0d got %0d want 2", k, t - prev); end
            end
            prev = t;
        end
        total++; if (sb.size() !== 0) begin bad++; $display("[TB] FAIL drain_left got %0d want 0", sb.size()); end
    endtask

    task automatic test_div_zero();
        int          acc_cyc;
        int          t;
        int          oe_cnt;
        bit          ok;
        bit          unst;
        logic [15:0] d;
        logic        e;
        res_ready = 1'b1;
        send(8'h10, 8'h00, OP_DIV, acc_cyc, ok);
        collect(1'b0, d, e, t, oe_cnt, unst, ok);
        void'(sb.pop_front());
        total++; if (!ok || d !== 16'hFFFF || e !== 1'b1) begin bad++; $display("[TB] FAIL div0_result got %h/%b want FFFF/1", d, e); end
        total++; if (oe_cnt !== 0) begin bad++; $display("[TB] FAIL div0_oe got %0d want 0", oe_cnt); end
        send(8'h10, 8'h04, OP_DIV, acc_cyc, ok);
        collect(1'b0, d, e, t, oe_cnt, unst, ok);
        void'(sb.pop_front());
        total++; if (!ok || d !== 16'h0004 || e !== 1'b0) begin bad++; $display("[TB] FAIL div4_result got %h/%b want 0004/0", d, e); end
        total++; if (oe_cnt !== 1) begin bad++; $display("[TB] FAIL div4_oe got %0d want 1", oe_cnt); end
    endtask

    task automatic test_all_opcodes();
        fork
            begin
                int acc_cyc;
                bit ok;
                for (int op = 0; op < 16; op++) begin
                    send(8'hCE, 8'h9B, 4'(op), acc_cyc, ok);
                end
            end
            begin
                int          t;
                int          oe_cnt;
                bit          ok;
                bit          unst;
                logic [15:0] d;
                logic        e;
                exp_t        ex;
                for (int k = 0; k < 16; k++) begin
                    collect(1'b1, d, e, t, oe_cnt, unst, ok);
                    ex = (sb.size() > 0) ? sb.pop_front() : exp_t'('0);
                    total++; if (!ok || d !== ex.data || e !== ex.err) begin bad++; $display("[TB] FAIL opcode%0d got %h/%b want %h/%b", k, d, e, ex.data, ex.err); end
                    total++; if (unst) begin bad++; $display("[TB] FAIL opcode%0d_stable got changed want held", k); end
                end
            end
        join
        res_ready = 1'b1;
    endtask

    task automatic test_reset_mid_drive();
        int          acc_cyc;
        int          t;
        int          oe_cnt;
        bit          ok;
        bit          unst;
        logic [15:0] d;
        logic        e;
        exp_t        ex;
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(tab_a[i], tab_b[i], tab_cmd[i], acc_cyc, ok);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        total++; if (alu_oe !== 1'b1 || fifo_count !== 3'd3) begin bad++; $display("[TB] FAIL pre_reset got oe=%b count=%0d want 1/3", alu_oe, fifo_count); end
        rst_n = 1'b0;
        #1;
        total++; if (res_valid !== 1'b0 || alu_oe !== 1'b0) begin bad++; $display("[TB] FAIL midreset_outputs got valid=%b oe=%b want 0/0", res_valid, alu_oe); end
        total++; if (fifo_count !== 3'd0 || in_ready !== 1'b1) begin bad++; $display("[TB] FAIL midreset_fifo got count=%0d ready=%b want 0/1", fifo_count, in_ready); end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        res_ready = 1'b1;
        send(8'h5A, 8'h3C, OP_XOR, acc_cyc, ok);
        collect(1'b0, d, e, t, oe_cnt, unst, ok);
        ex = (sb.size() > 0) ? sb.pop_front() : exp_t'('0);
        total++; if (!ok || d !== ex.data || e !== ex.err) begin bad++; $display("[TB] FAIL post_reset got %h/%b want %h/%b", d, e, ex.data, ex.err); end
    endtask

    task automatic test_full_backpressure();
        int          acc_cyc;
        int          nacc;
        int          nxt;
        int          t;
        int          oe_cnt;
        bit          ok;
        bit          unst;
        bit          acc;
        bit          hs;
        logic [15:0] d;
        logic        e;
        exp_t        ex;
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(tab_a[i], tab_b[i], tab_cmd[i], acc_cyc, ok);
        nxt = 0;
        in_a = tab_a[5]; in_b = tab_b[5]; in_cmd = tab_cmd[5]; in_valid = 1'b1;
        for (int w = 0; w < 4; w++) begin
            nacc = 0;
            for (int c = 0; c < 5; c++) begin
                res_ready = (c == 1);
                acc = in_valid && in_ready;
                hs  = res_valid && res_ready;
                d   = res_data;
                e   = res_err;
                step();
                if (hs) begin
                    ex = (sb.size() > 0) ? sb.pop_front() : exp_t'('0);
                    total++; if (d !== ex.data || e !== ex.err) begin bad++; $display("[TB] FAIL bp_result%0d got %h/%b want %h/%b", w, d, e, ex.data, ex.err); end
                end
                if (acc) begin
                    sb.push_back(expect_of(in_a, in_b, in_cmd));
                    nacc++;
                    nxt++;
                    if (nxt < 4) begin
                        in_a = tab_a[5 + nxt]; in_b = tab_b[5 + nxt]; in_cmd = tab_cmd[5 + nxt];
                    end else begin
                        in_valid = 1'b0;
                    end
                end
            end
            total++; if (nacc !== 1) begin bad++; $display("[TB] FAIL bp_accepts%0d got %0d want 1", w, nacc); end
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            collect(1'b0, d, e, t, oe_cnt, unst, ok);
            ex = (sb.size() > 0) ? sb.pop_front() : exp_t'('0);
            total++; if (!ok || d !== ex.data || e !== ex.err) begin bad++; $display("[TB] FAIL bp_drain%0d got %h/%b want %h/%b", k, d, e, ex.data, ex.err); end
        end
        total++; if (sb.size() !== 0 || res_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_left got %0d/%b want 0/0", sb.size(), res_valid); end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_fill_drain();
        test_div_zero();
        test_all_opcodes();
        test_reset_mid_drive();
        test_full_backpressure();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
